bbc_host_bus_resp_m: RTL

//  Motherboard-side responder for the accelerator's BBC bus port; a synthesisable host-bus model for board bring-up and CPLD verification.

---
 rtl/bbc_host_bus_resp_m.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/bbc_host_bus_resp_m.sv
// Motherboard-side BBC host-bus responder: generates bbc_phi0 (with 1MHz
// stretching for slow IO), serves bus reads/writes through a strobe memory
// port and holds the ROMSEL latch at FE30-FE33.
// Optional feature macro: BUS_TRACE_EN adds a transaction trace FIFO.
module bbc_host_bus_resp_m #(
    parameter int unsigned TRACE_DEPTH = 4
) (
    input  logic        clk16,
    input  logic        resetb,
    output logic        bbc_phi0,
    input  logic [15:0] bus_adr,
    input  logic        bus_rnw,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic        bus_doe,
    output logic [15:0] mem_adr,
    output logic        mem_rd_stb,
    input  logic [7:0]  mem_rdata,
    output logic        mem_wr_stb,
    output logic [7:0]  mem_wdata,
    output logic [3:0]  romsel,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [25:0] trace_data,
    output logic        trace_ovf
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TRACE_W = 26;

    typedef enum logic [1:0] {PHI1, STRETCH, PHI2} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [CNT_W-1:0]   ref_cnt_q;
    logic               long_q, long_d;
    logic               phi0_q, phi0_d;
    logic [15:0]        adr_q, adr_d;
    logic               rnw_q, rnw_d;
    logic               slow_q, slow_d;
    logic [7:0]         dout_q, dout_d;
    logic               doe_q, doe_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [3:0]         romsel_q, romsel_d;
    logic               rd_stb_q, rd_stb_d;
    logic               wr_stb_q, wr_stb_d;
    logic               rs_hit;
    logic [CNT_W-1:0]   phi2_last;

    // Slow (1MHz) IO regions: FC00-FDFF, FE00-FE1F, FE40-FE7F, FEC0-FEDF
    function automatic logic is_slow(input logic [15:0] a);
        return (a[15:9] == 7'b1111_110) || (a[15:5] == 11'b1111_1110_000) ||
               (a[15:6] == 10'b1111_1110_01) || (a[15:5] == 11'b1111_1110_110);
    endfunction

    assign rs_hit    = (adr_q[15:2] == 14'h3F8C);
    assign phi2_last = long_q ? 4'd7 : 4'd3;

    // Free-running 1MHz phase reference
    always_ff @(posedge clk16 or negedge resetb) begin
        if (!resetb) ref_cnt_q <= '0;
        else         ref_cnt_q <= ref_cnt_q + 4'd1;
    end

    // Bus-cycle sequencing, address decode and data path next-state
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q + 4'd1;
        long_d   = long_q;
        adr_d    = adr_q;
        rnw_d    = rnw_q;
        slow_d   = slow_q;
        dout_d   = dout_q;
        doe_d    = doe_q;
        wdata_d  = wdata_q;
        romsel_d = romsel_q;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
        phi0_d   = 1'b0;
        case (state_q)
            PHI1: begin
                if (ph_cnt_q == 4'd2) begin
                    adr_d  = bus_adr;
                    rnw_d  = bus_rnw;
                    slow_d = is_slow(bus_adr);
                end
                if (ph_cnt_q == 4'd3) begin
                    ph_cnt_d = '0;
                    if (!slow_q) begin
                        state_d = PHI2;
                        long_d  = 1'b0;
                    end else if (ref_cnt_q == 4'd7) begin
                        state_d = PHI2;
                        long_d  = 1'b1;
                    end else begin
                        state_d = STRETCH;
                    end
                end
            end
            STRETCH: begin
                if (ref_cnt_q == 4'd7) begin
                    state_d  = PHI2;
                    long_d   = 1'b1;
                    ph_cnt_d = '0;
                end
            end
            PHI2: begin
                if ((ph_cnt_q == 4'd0) && rnw_q && !rs_hit) begin
                    dout_d = mem_rdata;
                    doe_d  = 1'b1;
                end
                if (ph_cnt_q == phi2_last) begin
                    state_d  = PHI1;
                    ph_cnt_d = '0;
                    doe_d    = 1'b0;
                    if (!rnw_q) begin
                        wdata_d = bus_din;
                        if (rs_hit) romsel_d = bus_din[3:0];
                        else        wr_stb_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = PHI1;
                ph_cnt_d = '0;
            end
        endcase
        // Read request fires on the first PHI2 clock of a memory read
        rd_stb_d = (state_q != PHI2) && (state_d == PHI2) && rnw_q && !rs_hit;
        phi0_d   = (state_d == PHI2);
    end

    // State and output registers
    always_ff @(posedge clk16 or negedge resetb) begin
        if (!resetb) begin
            state_q  <= PHI1;
            ph_cnt_q <= '0;
            long_q   <= 1'b0;
            phi0_q   <= 1'b0;
            adr_q    <= '0;
            rnw_q    <= 1'b0;
            slow_q   <= 1'b0;
            dout_q   <= '0;
            doe_q    <= 1'b0;
            wdata_q  <= '0;
            romsel_q <= '0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_cnt_q <= ph_cnt_d;
            long_q   <= long_d;
            phi0_q   <= phi0_d;
            adr_q    <= adr_d;
            rnw_q    <= rnw_d;
            slow_q   <= slow_d;
            dout_q   <= dout_d;
            doe_q    <= doe_d;
            wdata_q  <= wdata_d;
            romsel_q <= romsel_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
        end
    end

    assign bbc_phi0   = phi0_q;
    assign bus_dout   = dout_q;
    assign bus_doe    = doe_q;
    assign mem_adr    = adr_q;
    assign mem_rd_stb = rd_stb_q;
    assign mem_wr_stb = wr_stb_q;
    assign mem_wdata  = wdata_q;
    assign romsel     = romsel_q;

`ifdef BUS_TRACE_EN
    localparam int unsigned PTR_W  = $clog2(TRACE_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    logic [TRACE_W-1:0] fifo_mem [TRACE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0]  fcnt_q;
    logic               ovf_q;
    logic               done_q;
    logic               push, pop, full, accept;
    logic [7:0]         trace_byte;
    logic [TRACE_W-1:0] push_data;

    // Completed cycle is recorded during the first clock of the next PHI1
    assign push       = done_q;
    assign pop        = trace_valid && trace_ready;
    assign full       = (fcnt_q == FCNT_W'(TRACE_DEPTH));
    assign accept     = push && (!full || pop);
    assign trace_byte = rnw_q ? (rs_hit ? 8'hFF : dout_q) : wdata_q;
    assign push_data  = {slow_q, rnw_q, adr_q, trace_byte};

    // Trace FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk16 or negedge resetb) begin
        if (!resetb) begin
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= (state_q == PHI2) && (state_d == PHI1);
            if (accept) wr_ptr_q <= PTR_W'(wr_ptr_q + 1'b1);
            if (pop)    rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
            if (accept && !pop)      fcnt_q <= FCNT_W'(fcnt_q + 1'b1);
            else if (!accept && pop) fcnt_q <= FCNT_W'(fcnt_q - 1'b1);
            if (push && !accept) ovf_q <= 1'b1;
        end
    end

    // Trace FIFO storage
    always_ff @(posedge clk16) begin
        if (accept) fifo_mem[wr_ptr_q] <= push_data;
    end

    assign trace_valid = (fcnt_q != '0);
    assign trace_data  = fifo_mem[rd_ptr_q];
    assign trace_ovf   = ovf_q;
`else
    logic [31:0] unused_trace;
    assign unused_trace = {31'(TRACE_DEPTH), trace_ready};
    assign trace_valid  = 1'b0;
    assign trace_data   = '0;
    assign trace_ovf    = 1'b0;
`endif

endmodule
